// File: rtl/regfile_writer_pkg.sv
// Shared types and helpers for the register-file writeback buffer.
package regfile_writer_pkg;
    localparam int WIDTH_DEF = 8;
    localparam int AW_DEF    = 3;

    localparam logic [AW_DEF-1:0] PC_ALIAS_ADDR = '1;

    typedef struct packed {
        logic [AW_DEF-1:0]    addr;
        logic [WIDTH_DEF-1:0] data;
    } wb_entry_t;

    // The PC alias is the all-ones address at whatever address width is in use.
    function automatic logic is_pc_addr(input logic [31:0] addr, input int aw);
        return addr == ((32'd1 << aw) - 32'd1);
    endfunction
endpackage

// File: rtl/regfile_writer_if.sv
// Writeback bus: two result sources in, regfile/PC write port and status out.
// Forwarding lookup signals exist only with REGFILE_WRITER_FWD_EN.
interface regfile_writer_if #(
    parameter int WIDTH        = 8,
    parameter int REGNUM       = 8,
    parameter int ADDRESSWIDTH = 3,
    parameter int DEPTH        = 4
);
    logic                      mem_valid, mem_ready;
    logic [ADDRESSWIDTH-1:0]   mem_addr;
    logic [WIDTH-1:0]          mem_data;
    logic                      alu_valid, alu_ready;
    logic [ADDRESSWIDTH-1:0]   alu_addr;
    logic [WIDTH-1:0]          alu_data;
    logic                      we3;
    logic [ADDRESSWIDTH-1:0]   wa3;
    logic [WIDTH-1:0]          wd3;
    logic                      pc_we;
    logic [WIDTH-1:0]          pc_wd;
    logic [REGNUM-1:0]         pending;
    logic [$clog2(DEPTH):0]    count;
`ifdef REGFILE_WRITER_FWD_EN
    logic [ADDRESSWIDTH-1:0]   fwd_ra;
    logic                      fwd_hit;
    logic [WIDTH-1:0]          fwd_data;
`endif

    modport master (
`ifdef REGFILE_WRITER_FWD_EN
        output fwd_ra, input fwd_hit, fwd_data,
`endif
        output mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data,
        input  mem_ready, alu_ready, we3, wa3, wd3, pc_we, pc_wd, pending, count
    );

    modport slave (
`ifdef REGFILE_WRITER_FWD_EN
        input fwd_ra, output fwd_hit, fwd_data,
`endif
        input  mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data,
        output mem_ready, alu_ready, we3, wa3, wd3, pc_we, pc_wd, pending, count
    );
endinterface

// File: rtl/regfile_writer_fifo.sv
// wb_fifo: circular buffer, up to two pushes and one pop per cycle; exposes
// the raw entry array and a valid mask for pending/forwarding lookups.
module wb_fifo import regfile_writer_pkg::*; #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_entry_t,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       npush,
    input  entry_t           d0,
    input  entry_t           d1,
    input  logic             pop,
    output entry_t           ents [DEPTH],
    output logic [DEPTH-1:0] vld,
    output logic [PW-1:0]    head,
    output logic [CW-1:0]    count
);
    logic [PW-1:0] tail;
    entry_t        mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop);
            tail  <= tail + PW'(npush);
            count <= count + CW'(npush) - CW'(pop);
        end
    end

    // Storage needs no reset: only slots inside the count window are ever read.
    always_ff @(posedge clk) begin
        if (npush != 2'd0) mem[tail] <= d0;
        if (npush == 2'd2) mem[tail + PW'(1)] <= d1;
    end

    assign ents = mem;

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            vld[i] = {1'b0, PW'(i) - head} < count;
    end
endmodule

// File: rtl/regfile_writer.sv
// Writeback producer: buffers load/ALU results in order and retires one per
// cycle to the regfile or PC port. Optional REGFILE_WRITER_FWD_EN adds a lookup.
module regfile_writer import regfile_writer_pkg::*; #(
    parameter int WIDTH        = 8,
    parameter int REGNUM       = 8,
    parameter int ADDRESSWIDTH = 3,
    parameter int DEPTH        = 4
) (
    input  logic            clk,
    input  logic            rst,
    regfile_writer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDRESSWIDTH-1:0] addr;
        logic [WIDTH-1:0]        data;
    } ent_t;

    ent_t              ents [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic [PW-1:0]     head;
    logic [CW-1:0]     count, free;
    logic              pop, mem_push, alu_push, hd_pc;
    logic [1:0]        npush;
    ent_t              mem_e, alu_e, d0, hd;
    logic [REGNUM-1:0] pend;

    // The slot retiring this cycle is already free for an incoming push.
    assign pop      = count != '0;
    assign free     = CW'(DEPTH) - count + CW'(pop);
    assign bus.mem_ready = !rst && (free >= CW'(1));
    assign bus.alu_ready = !rst && (free >= CW'(1) + CW'(mem_push));
    assign mem_push = bus.mem_valid & bus.mem_ready;
    assign alu_push = bus.alu_valid & bus.alu_ready;
    assign npush    = {1'b0, mem_push} + {1'b0, alu_push};

    // Load is the older instruction, so it takes the first slot.
    assign mem_e = '{addr: bus.mem_addr, data: bus.mem_data};
    assign alu_e = '{addr: bus.alu_addr, data: bus.alu_data};
    assign d0    = mem_push ? mem_e : alu_e;

    wb_fifo #(.DEPTH(DEPTH), .entry_t(ent_t)) u_fifo (
        .clk(clk), .rst(rst), .npush(npush), .d0(d0), .d1(alu_e), .pop(pop),
        .ents(ents), .vld(vld), .head(head), .count(count)
    );

    assign hd        = ents[head];
    assign hd_pc     = is_pc_addr(32'(hd.addr), ADDRESSWIDTH);
    assign bus.we3   = pop & !hd_pc;
    assign bus.wa3   = bus.we3 ? hd.addr : '0;
    assign bus.wd3   = bus.we3 ? hd.data : '0;
    assign bus.pc_we = pop & hd_pc;
    assign bus.pc_wd = bus.pc_we ? hd.data : '0;
    assign bus.count = count;

    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++)
            if (vld[i]) pend[ents[i].addr] = 1'b1;
    end
    assign bus.pending = pend;

`ifdef REGFILE_WRITER_FWD_EN
    logic             fwd_hit;
    logic [WIDTH-1:0] fwd_data;

    // Walk oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (vld[head + PW'(k)] && ents[head + PW'(k)].addr == bus.fwd_ra) begin
                fwd_hit  = 1'b1;
                fwd_data = ents[head + PW'(k)].data;
            end
        end
    end
    assign bus.fwd_hit  = fwd_hit;
    assign bus.fwd_data = fwd_data;
`endif
endmodule

// File: tb/tb_regfile_writer.sv
// Directed bench for regfile_writer: reset, single/dual push, PC alias,
// fill with scoreboard, reset mid-burst and (optionally) forwarding.
module tb_regfile_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_writer_if #(.WIDTH(8), .REGNUM(8), .ADDRESSWIDTH(3), .DEPTH(4)) bus();

    regfile_writer #(.WIDTH(8), .REGNUM(8), .ADDRESSWIDTH(3), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    task automatic idle();
        bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
        bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if ({bus.we3, bus.wa3, bus.wd3} !== 12'h0) begin errors++; $display("FAIL reset_wport: got %0b/%0d/%h want 0/0/00", bus.we3, bus.wa3, bus.wd3); end
        checks++; if ({bus.pc_we, bus.pc_wd} !== 9'h0) begin errors++; $display("FAIL reset_pc: got %0b/%h want 0/00", bus.pc_we, bus.pc_wd); end
        checks++; if (bus.pending !== 8'h00 || bus.count !== 3'd0) begin errors++; $display("FAIL reset_state: pending %h count %0d want 00 0", bus.pending, bus.count); end
        checks++; if ({bus.mem_ready, bus.alu_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready_in_rst: got %b want 00", {bus.mem_ready, bus.alu_ready}); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        checks++; if ({bus.mem_ready, bus.alu_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready_after: got %b want 11", {bus.mem_ready, bus.alu_ready}); end
    endtask

    task automatic test_single_alu();
        @(negedge clk);
        bus.alu_valid = 1'b1; bus.alu_addr = 3'd2; bus.alu_data = 8'h5A; #1;
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", bus.alu_ready); end
        @(posedge clk); #1; idle();
        checks++; if ({bus.we3, bus.wa3, bus.wd3} !== {1'b1, 3'd2, 8'h5A}) begin errors++; $display("FAIL single_write: got %0b/%0d/%h want 1/2/5a", bus.we3, bus.wa3, bus.wd3); end
        checks++; if (bus.pending !== 8'h04 || bus.count !== 3'd1) begin errors++; $display("FAIL single_pending: pending %h count %0d want 04 1", bus.pending, bus.count); end
        @(posedge clk); #1;
        checks++; if (bus.we3 !== 1'b0 || bus.pending !== 8'h00) begin errors++; $display("FAIL single_drain: we3 %b pending %h want 0 00", bus.we3, bus.pending); end
    endtask

    task automatic test_dual();
        @(negedge clk);
        bus.mem_valid = 1'b1; bus.mem_addr = 3'd1; bus.mem_data = 8'h11;
        bus.alu_valid = 1'b1; bus.alu_addr = 3'd1; bus.alu_data = 8'h22; #1;
        checks++; if ({bus.mem_ready, bus.alu_ready} !== 2'b11) begin errors++; $display("FAIL dual_ready: got %b want 11", {bus.mem_ready, bus.alu_ready}); end
        @(posedge clk); #1; idle();
        checks++; if ({bus.count, bus.we3, bus.wa3, bus.wd3} !== {3'd2, 1'b1, 3'd1, 8'h11}) begin errors++; $display("FAIL dual_first: count %0d we3 %b wa3 %0d wd3 %h want 2 1 1 11", bus.count, bus.we3, bus.wa3, bus.wd3); end
        checks++; if (bus.pending !== 8'h02) begin errors++; $display("FAIL dual_pending: got %h want 02", bus.pending); end
        @(posedge clk); #1;
        checks++; if ({bus.count, bus.we3, bus.wa3, bus.wd3} !== {3'd1, 1'b1, 3'd1, 8'h22}) begin errors++; $display("FAIL dual_second: count %0d we3 %b wa3 %0d wd3 %h want 1 1 1 22", bus.count, bus.we3, bus.wa3, bus.wd3); end
        @(posedge clk); #1;
        checks++; if (bus.count !== 3'd0 || bus.we3 !== 1'b0) begin errors++; $display("FAIL dual_empty: count %0d we3 %b want 0 0", bus.count, bus.we3); end
    endtask

    task automatic test_pc_alias();
        @(negedge clk);
        bus.alu_valid = 1'b1; bus.alu_addr = 3'd7; bus.alu_data = 8'h40;
        @(posedge clk); #1; idle();
        checks++; if ({bus.pc_we, bus.pc_wd, bus.we3} !== {1'b1, 8'h40, 1'b0}) begin errors++; $display("FAIL pc_route: pc_we %b pc_wd %h we3 %b want 1 40 0", bus.pc_we, bus.pc_wd, bus.we3); end
        checks++; if (bus.pending !== 8'h80 || bus.wa3 !== 3'd0 || bus.wd3 !== 8'h00) begin errors++; $display("FAIL pc_side: pending %h wa3 %0d wd3 %h want 80 0 00", bus.pending, bus.wa3, bus.wd3); end
        @(posedge clk); #1;
        checks++; if (bus.pc_we !== 1'b0 || bus.pc_wd !== 8'h00) begin errors++; $display("FAIL pc_clear: pc_we %b pc_wd %h want 0 00", bus.pc_we, bus.pc_wd); end
    endtask

    task automatic test_fill();
        logic [10:0] q[$];
        int mc, free;
        logic emr, ear;
        bit saw_full = 0, saw_drop = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.mem_valid = 1'b1; bus.mem_addr = 3'(i % 7);       bus.mem_data = 8'(8'h10 + i);
            bus.alu_valid = 1'b1; bus.alu_addr = 3'((i + 3) % 7); bus.alu_data = 8'(8'hA0 + i);
            #1;
            mc = q.size();
            free = 4 - mc + ((mc != 0) ? 1 : 0);
            emr = free >= 1;
            ear = free >= 1 + int'(emr);
            checks++; if (bus.count !== 3'(mc)) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus.count, mc); end
            checks++; if ({bus.mem_ready, bus.alu_ready} !== {emr, ear}) begin errors++; $display("FAIL fill_ready[%0d]: got %b want %b", i, {bus.mem_ready, bus.alu_ready}, {emr, ear}); end
            if (mc != 0) begin
                checks++; if ({bus.we3, bus.wa3, bus.wd3} !== {1'b1, q[0]}) begin errors++; $display("FAIL fill_head[%0d]: got %0b/%0d/%h want 1/%0d/%h", i, bus.we3, bus.wa3, bus.wd3, q[0][10:8], q[0][7:0]); end
            end
            if (bus.count === 3'd4) saw_full = 1;
            if (bus.alu_ready === 1'b0) saw_drop = 1;
            @(posedge clk);
            if (q.size() != 0) void'(q.pop_front());
            if (emr) q.push_back({bus.mem_addr, bus.mem_data});
            if (ear) q.push_back({bus.alu_addr, bus.alu_data});
        end
        checks++; if (!saw_full || !saw_drop) begin errors++; $display("FAIL fill_saturate: saw_full %0d saw_alu_drop %0d want 1 1", saw_full, saw_drop); end
        @(negedge clk); idle();
        for (int c = 0; c < 8 && q.size() != 0; c++) begin
            #1;
            checks++; if (bus.count !== 3'(q.size()) || {bus.we3, bus.wa3, bus.wd3} !== {1'b1, q[0]}) begin errors++; $display("FAIL drain[%0d]: count %0d got %0b/%0d/%h want %0d 1/%0d/%h", c, bus.count, bus.we3, bus.wa3, bus.wd3, q.size(), q[0][10:8], q[0][7:0]); end
            @(posedge clk);
            void'(q.pop_front());
            @(negedge clk);
        end
        #1;
        checks++; if (bus.count !== 3'd0 || bus.we3 !== 1'b0) begin errors++; $display("FAIL drain_end: count %0d we3 %b want 0 0", bus.count, bus.we3); end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        bus.mem_valid = 1'b1; bus.mem_addr = 3'd1; bus.mem_data = 8'h31;
        bus.alu_valid = 1'b1; bus.alu_addr = 3'd2; bus.alu_data = 8'h32;
        @(negedge clk);
        bus.mem_addr = 3'd4; bus.mem_data = 8'h33;
        bus.alu_addr = 3'd5; bus.alu_data = 8'h34;
        @(negedge clk); idle(); #1;
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL rstmid_pre: count %0d want 3", bus.count); end
        #1; rst = 1'b1; #1;
        checks++; if (bus.we3 !== 1'b0 || bus.pending !== 8'h00 || bus.count !== 3'd0) begin errors++; $display("FAIL rstmid_clear: we3 %b pending %h count %0d want 0 00 0", bus.we3, bus.pending, bus.count); end
        checks++; if ({bus.mem_ready, bus.alu_ready} !== 2'b00) begin errors++; $display("FAIL rstmid_ready: got %b want 00", {bus.mem_ready, bus.alu_ready}); end
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++; if (bus.we3 !== 1'b0 || bus.pc_we !== 1'b0 || bus.count !== 3'd0) begin errors++; $display("FAIL rstmid_stale[%0d]: we3 %b pc_we %b count %0d want 0 0 0", c, bus.we3, bus.pc_we, bus.count); end
        end
    endtask

`ifdef REGFILE_WRITER_FWD_EN
    task automatic test_fwd();
        @(negedge clk);
        bus.mem_valid = 1'b1; bus.mem_addr = 3'd3; bus.mem_data = 8'hAA;
        bus.alu_valid = 1'b1; bus.alu_addr = 3'd3; bus.alu_data = 8'hBB;
        @(posedge clk); #1; idle();
        bus.fwd_ra = 3'd3; #1;
        checks++; if ({bus.fwd_hit, bus.fwd_data} !== {1'b1, 8'hBB}) begin errors++; $display("FAIL fwd_young: got %b/%h want 1/bb", bus.fwd_hit, bus.fwd_data); end
        bus.fwd_ra = 3'd4; #1;
        checks++; if ({bus.fwd_hit, bus.fwd_data} !== {1'b0, 8'h00}) begin errors++; $display("FAIL fwd_miss: got %b/%h want 0/00", bus.fwd_hit, bus.fwd_data); end
        @(posedge clk); #1;
        bus.fwd_ra = 3'd3; #1;
        checks++; if ({bus.fwd_hit, bus.fwd_data} !== {1'b1, 8'hBB}) begin errors++; $display("FAIL fwd_remain: got %b/%h want 1/bb", bus.fwd_hit, bus.fwd_data); end
        @(posedge clk); #1;
        checks++; if (bus.fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_empty: got %b want 0", bus.fwd_hit); end
    endtask
`endif

    initial begin
        idle();
`ifdef REGFILE_WRITER_FWD_EN
        bus.fwd_ra = '0;
`endif
        test_reset();
        test_single_alu();
        test_dual();
        test_pc_alias();
        test_fill();
        test_reset_mid_burst();
`ifdef REGFILE_WRITER_FWD_EN
        test_fwd();
`endif
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/regfile_writer.md
Name: regfile_writer

Overview:
- Writeback-side producer for the processor register file: collects results from the load unit and the ALU, buffers them in order, and drives the regfile write port (we3/wa3/wd3) at one write per cycle.
- Register address all-ones is the PC alias, which the register file cannot store. Writes to it leave on a separate PC-redirect port.
- Exports a per-register pending vector so decode can stall on buffered writes.

Parameters:
- WIDTH, 8, data width of one register.
- REGNUM, 8, number of architectural registers.
- ADDRESSWIDTH, 3, register address width.
- DEPTH, 4, write-buffer entries; power of 2, at least 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- mem_valid  input  1  load result offered.
- mem_ready  output  1  load result accepted this cycle when mem_valid is also high.
- mem_addr  input  ADDRESSWIDTH  destination register of the load.
- mem_data  input  WIDTH  load data.
- alu_valid  input  1  ALU result offered.
- alu_ready  output  1  ALU result accepted this cycle when alu_valid is also high.
- alu_addr  input  ADDRESSWIDTH  destination register of the ALU result.
- alu_data  input  WIDTH  ALU data.
- we3  output  1  regfile write enable.
- wa3  output  ADDRESSWIDTH  regfile write address.
- wd3  output  WIDTH  regfile write data.
- pc_we  output  1  PC redirect strobe.
- pc_wd  output  WIDTH  PC redirect value.
- pending  output  REGNUM  bit i high when any buffered entry targets register i.
- count  output  $clog2(DEPTH)+1  number of buffered entries.

Behaviour:
- Circular FIFO with head/tail pointers plus an occupancy counter. Entry = {addr, data}.
- Pop: whenever count != 0, the head entry is presented this cycle and popped at the next posedge. The regfile never back-pressures.
- Head routing: if head addr != all-ones, drive we3=1, wa3=addr, wd3=data, pc_we=0. If head addr == all-ones, drive pc_we=1, pc_wd=data, we3=0.
- When empty: we3=0, pc_we=0; wa3, wd3 and pc_wd are 0.
- Outputs come from stored FIFO state only; there is no combinational path from any input to we3, wa3, wd3, pc_we or pc_wd.
- Latency: a request accepted at edge N is written at edge N+1 at the earliest (one cycle in the buffer).
- Up to two pushes per cycle. The load result is the older instruction, so it is pushed first at tail and the ALU result at tail+1.
- free = DEPTH - count + (count != 0 ? 1 : 0). This counts the entry being popped this cycle.
- Ready rules:
  - mem_ready = (free >= 1).
  - alu_ready = (free >= 1 + (mem_valid & mem_ready)).
  - Ready may depend on valid. Sources must not make valid depend on ready.
- Counter update: count_next = count + pushes - pop. It never exceeds DEPTH and never underflows.
- Pointers wrap modulo DEPTH.
- pending is combinational over valid entries only; in-flight inputs are not included. The all-ones bit reflects pending PC writes.
- Same-address entries are retired in FIFO order, so the last write wins.
- Reset, at any time including mid-burst: pointers and count go to 0; buffered entries are discarded.
  - Reset values: we3=0, wa3=0, wd3=0, pc_we=0, pc_wd=0, pending=0, count=0.
  - mem_ready=alu_ready=1 while rst is low and count is 0.
  - While rst is high, both ready outputs are forced to 0.

Optional Feature:
- Macro REGFILE_WRITER_FWD_EN adds a forwarding lookup for decode:
  - Ports: fwd_ra input ADDRESSWIDTH; fwd_hit output 1; fwd_data output WIDTH.
  - fwd_hit=1 when any buffered entry matches fwd_ra. fwd_data is then the youngest matching entry, searching from tail toward head.
  - Otherwise fwd_hit=0 and fwd_data=0. The lookup is combinational.
- Without the macro these ports do not exist. Decode must stall on pending.

Decomposition:
- Package regfile_writer_pkg holds:
  - wb_entry_t struct {addr, data}, sized from the default parameters.
  - PC_ALIAS_ADDR = all-ones constant.
  - Helper function is_pc_addr.
- One natural sub-module: wb_fifo, a 2-push/1-pop circular buffer that exposes the entry array and valid mask for the pending and forwarding logic.

Test Plan:
- Single ALU push: addr=2, data=0x5A, buffer empty. Required: alu_ready=1; next cycle we3=1, wa3=2, wd3=0x5A, pending[2]=1; the cycle after, we3=0 and pending=0.
- Dual push: mem(addr=1, 0x11) and alu(addr=1, 0x22) in the same cycle. Required: regfile writes 0x11 then 0x22 on consecutive cycles; count goes 2, 1, 0.
- PC alias: alu addr=7, data=0x40. Required: next cycle pc_we=1, pc_wd=0x40, we3=0.
- Fill: both sources valid every cycle, DEPTH=4. Required: count saturates at 4; alu_ready drops while mem_valid is high; exactly one entry drains per cycle; no entry is lost or reordered (scoreboard check).
- Reset mid-burst: assert rst with count=3. Required: immediately we3=0, pending=0, count=0; after rst deasserts, no stale writes occur.
- With REGFILE_WRITER_FWD_EN: buffer holds addr=3 entries 0xAA (older) and 0xBB (younger), fwd_ra=3. Required: fwd_hit=1, fwd_data=0xBB; with fwd_ra=4, fwd_hit=0.
